// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared state encoding, line levels and parity helpers for UART TX
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_DATA_W = 9;

  // Zero-extension to MAX_DATA_W leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// uart_baud_cnt : bit-period counter, one-cycle bit_tick every PERIOD cycles
// Rev 1.0
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  output logic               bit_tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // period is never zero while en is high; the caller clamps it at latch time.
  assign bit_tick = en && (cnt_q == (period - 1'b1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_tx_ctrl : UART frame sequencer (start, data LSB-first, parity, stop)
// Rev 1.0
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int IN_width = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IN_width-1:0] P_DATA,
  input  logic                DATA_valid,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic                STOP2,
  input  logic [PRESC_W-1:0]  PRESCALE,
  output logic                TX_OUT,
  output logic                busy,
  output logic                tx_done
);

  localparam int IDX_W = $clog2(IN_width) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_width - 1);

  tx_state_e           state_q, state_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                tx_done_q, tx_done_d;
  logic [IN_width-1:0] sh_q, sh_d;
  logic                par_q, par_d;
  logic                par_en_q, par_en_d;
  logic                stop2_q, stop2_d;
  logic [PRESC_W-1:0]  period_q, period_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                  accept;
  logic                  bit_tick;
  logic [MAX_DATA_W-1:0] word_ext;

  always_comb begin
    word_ext = '0;
    word_ext[IN_width-1:0] = P_DATA;
  end

  uart_baud_cnt #(
    .PRESC_W (PRESC_W)
  ) u_baud (
    .clk      (CLK),
    .rst      (RST),
    .clr      (accept),
    .en       (busy_q),
    .period   (period_q),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    sh_d      = sh_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    period_d  = period_q;
    idx_d     = idx_q;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (DATA_valid) begin
          accept   = 1'b1;
          state_d  = ST_START;
          tx_d     = LINE_START;
          busy_d   = 1'b1;
          sh_d     = P_DATA;
          par_d    = parity_bit(word_ext, PAR_TYP);
          par_en_d = PAR_EN;
          stop2_d  = STOP2;
          period_d = (PRESCALE == '0) ? PRESC_W'(1) : PRESCALE;
          idx_d    = '0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = LINE_STOP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = LINE_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        // idx counts completed stop bits when two are requested.
        if (bit_tick) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IDX_W'(1);
          end else begin
            state_d   = ST_IDLE;
            tx_d      = LINE_IDLE;
            busy_d    = 1'b0;
            tx_done_d = 1'b1;
            idx_d     = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      period_q  <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      period_q  <= period_d;
      idx_q     <= idx_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_ctrl : scoreboard bench for the UART TX frame sequencer
// Rev 1.0
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  P_DATA = '0;
  logic          DATA_valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic [PW-1:0] PRESCALE = '0;
  logic          TX_OUT;
  logic          busy;
  logic          tx_done;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(
    .IN_width (W),
    .PRESC_W  (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_valid (DATA_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // Called #1 after an edge: pushes the expected line trace, then presents the request.
  task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             input logic s2, input logic [PW-1:0] ps);
    int   p;
    logic bits[$];
    p = (ps == '0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) for (int j = 0; j < p; j++) exp_q.push_back(bits[i]);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps;
    DATA_valid = 1'b1;
    @(posedge CLK); #1;
    DATA_valid = 1'b0;
  endtask

  // mode 0: quiet inputs, 1: stray request mid-frame, 2: inputs scrambled every cycle
  task automatic check_frame(input string name, input int mode);
    int   k;
    logic e;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (TX_OUT !== e || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s cycle%0d: tx=%b busy=%b, required tx=%b busy=1", name, k, TX_OUT, busy, e);
      end
      if (mode == 1) begin
        DATA_valid = (k == 5);
        P_DATA     = 8'h55;
      end else if (mode == 2) begin
        P_DATA   = W'($urandom);
        PAR_TYP  = 1'($urandom);
        PAR_EN   = 1'($urandom);
        STOP2    = 1'($urandom);
        PRESCALE = PW'($urandom_range(0, 7));
      end
      k++;
      @(posedge CLK); #1;
    end
    n_cmp++;
    if (busy !== 1'b0 || tx_done !== 1'b1 || TX_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL %s end: busy=%b tx_done=%b tx=%b, required busy=0 tx_done=1 tx=1",
               name, busy, tx_done, TX_OUT);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: tx=%b busy=%b tx_done=%b, required 1/0/0", TX_OUT, busy, tx_done);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_parity_even;
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8'd4);
    check_frame("even_p4", 0);
    @(posedge CLK); #1;
    n_cmp++;
    if (tx_done !== 1'b0 || busy !== 1'b0 || TX_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL even_p4 pulse: tx_done=%b busy=%b tx=%b, required 0/0/1", tx_done, busy, TX_OUT);
    end
  endtask

  task automatic test_odd_stop2;
    start_frame(8'h07, 1'b1, 1'b1, 1'b1, 8'd1);
    check_frame("odd_stop2", 0);
    @(posedge CLK); #1;
    n_cmp++;
    if (tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL odd_stop2 pulse: tx_done=%b, required 0", tx_done);
    end
  endtask

  task automatic test_prescale_zero;
    start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'd0);
    check_frame("presc0", 0);
    @(posedge CLK); #1;
    n_cmp++;
    if (tx_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL presc0 pulse: tx_done=%b busy=%b, required 0/0", tx_done, busy);
    end
  endtask

  task automatic test_back_to_back;
    start_frame(8'h81, 1'b0, 1'b0, 1'b1, 8'd2);
    check_frame("b2b_first", 1);
    // Still in the tx_done cycle: this request must be taken without a gap.
    start_frame(8'h12, 1'b1, 1'b0, 1'b0, 8'd3);
    check_frame("b2b_second", 0);
    @(posedge CLK); #1;
    n_cmp++;
    if (tx_done !== 1'b0 || busy !== 1'b0 || TX_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL b2b idle: tx_done=%b busy=%b tx=%b, required 0/0/1", tx_done, busy, TX_OUT);
    end
  endtask

  task automatic test_scramble;
    start_frame(8'hC3, 1'b1, 1'b1, 1'b0, 8'd3);
    check_frame("scramble", 2);
    @(posedge CLK); #1;
    n_cmp++;
    if (tx_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL scramble pulse: tx_done=%b busy=%b, required 0/0", tx_done, busy);
    end
  endtask

  task automatic test_reset_midframe;
    logic e;
    start_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8'd4);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (TX_OUT !== e || busy !== 1'b1) begin
        n_err++;
        $display("FAIL rst_mid pre cycle%0d: tx=%b busy=%b, required tx=%b busy=1", k, TX_OUT, busy, e);
      end
      @(posedge CLK); #1;
    end
    exp_q.delete();
    RST = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid edge: tx=%b busy=%b tx_done=%b, required 1/0/0", TX_OUT, busy, tx_done);
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid idle cycle%0d: tx=%b busy=%b tx_done=%b, required 1/0/0",
                 k, TX_OUT, busy, tx_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_odd_stop2();
    test_prescale_zero();
    test_back_to_back();
    test_scramble();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that sequences a complete TX frame: start bit, data bits LSB-first, optional parity bit, and one or two stop bits.
It accepts a parallel word with a valid strobe, latches the word and its frame configuration, and paces each bit with an internal baud prescaler.
It drives the serial line directly and reports busy and frame-done status.
It sits between the host/FIFO side and the TX pin, replacing ad-hoc coupling of the parity, serializer and mux logic.

Parameters:
IN_width, 8, number of data bits per frame (valid range 5..9)
PRESC_W, 8, width of the PRESCALE input (clock cycles per bit)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  IN_width  parallel data word to transmit
DATA_valid  input  1  single-cycle request to send P_DATA; honoured only when busy=0
PAR_EN  input  1  1 = parity bit included in the frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  1 = two stop bits, 0 = one stop bit
PRESCALE  input  PRESC_W  CLK cycles per bit; 0 is treated as 1
TX_OUT  output  1  serial line output, idles high
busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse on the cycle after the final stop bit ends

Behaviour:
- Reset values: synchronous RST=1 at a rising edge forces TX_OUT=1, busy=0, tx_done=0, state=IDLE, and clears all counters.
- Reset has priority over every other input, including mid-frame: the line returns high on that edge and the frame is abandoned without a tx_done pulse.
- States and transitions: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
- Acceptance: in IDLE, DATA_valid=1 at edge N latches P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE.
  - From edge N: TX_OUT=0 (start bit) and busy=1.
  - Inputs changing after acceptance do not affect the frame in flight.
- DATA_valid while busy=1 is ignored, with no queuing.
- Bit timing:
  - Each bit is held for exactly P cycles, where P = max(PRESCALE_latched, 1).
  - The baud counter counts 0..P-1; bit advance occurs when the count reaches P-1.
- DATA state:
  - A bit index runs 0..IN_width-1; TX_OUT = data_latched[index], LSB first.
  - After index IN_width-1 the FSM goes to PARITY if PAR_EN, else to STOP.
- Parity:
  - Computed from the latched word at acceptance: even = ^data, odd = ~^data.
  - It is transmitted for one bit time.
- STOP state:
  - TX_OUT=1 for P cycles, or 2P cycles if STOP2.
  - At the end: state=IDLE, busy=0, tx_done=1 for exactly one cycle.
- Frame length in cycles = P × (1 + IN_width + PAR_EN + 1 + STOP2).
- Back-to-back: the earliest next acceptance is the edge at which busy=0 is first visible, i.e. the tx_done cycle. That cycle's DATA_valid is accepted.
- The IDLE line level is 1.
- TX_OUT is fully registered (glitch-free); no combinational path from inputs to TX_OUT.
- The bit counter must not overflow for IN_width up to 9; size it as clog2(IN_width)+1 bits.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE, START, DATA, PARITY, STOP), line idle/start/stop levels, and parity type constants (EVEN=0, ODD=1).
- One natural sub-module: uart_baud_cnt.
  - Loadable down/up counter producing a one-cycle bit_tick every P cycles.
  - Cleared on frame acceptance and on RST.
- The FSM, shift/index logic and parity latch stay in uart_tx_ctrl.

Test Plan:
- RST=1 for 3 cycles mid-frame (PRESCALE=4, P_DATA=0xFF) -> TX_OUT=1, busy=0, tx_done=0 on the edge after RST. No further frame activity until a new DATA_valid.
- PRESCALE=4, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> line sequence 0, 1,0,1,0,0,1,0,1, 0(parity), 1, each bit 4 cycles. busy high 44 cycles, then tx_done pulses once.
- PRESCALE=1, P_DATA=0x07, PAR_EN=1, PAR_TYP=1, STOP2=1 -> 0, 1,1,1,0,0,0,0,0, 0(odd parity), 1, 1; total 12 cycles.
- PRESCALE=0, P_DATA=0x3C, PAR_EN=0, STOP2=0 -> behaves as P=1: 10-cycle frame, no parity bit.
- DATA_valid with P_DATA=0x55 asserted mid-frame, then 0x12 on the tx_done cycle -> 0x55 is dropped. 0x12's start bit begins the edge after tx_done, with no idle gap beyond that edge.
- Change P_DATA/PAR_TYP/PRESCALE every cycle during a frame -> transmitted bits and timing match the values latched at acceptance only.
